runner_game_core: RTL and testbench
===================================

RUNNER_GAME_CORE -- requirements
Module: runner_game_core

Interface
REQ-001 SHALL have parameter COLS, default 16, meaning number of field cells (cell 0 is the dino column), range 4..32.
REQ-002 SHALL have parameter TICK_CYCLES, default 250000, meaning CLK cycles per game tick at level 0, a multiple of 8.
REQ-003 SHALL have parameter JUMP_TICKS, default 3, meaning ticks the dino stays airborne per jump, range 1..7.
REQ-004 SHALL have parameter MIN_GAP, default 5, meaning number of empty top cells required before a new obstacle may spawn, range 1..COLS-1.
REQ-005 SHALL have parameter SPEEDUP_SCORE, default 64, meaning score increment per speed level, a power of two.
REQ-006 SHALL have port CLK, input, 1 bit: system clock.
REQ-007 SHALL have port RESETN, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port START, input, 1 bit: single-cycle start/acknowledge pulse.
REQ-009 SHALL have port JUMP, input, 1 bit: single-cycle jump request pulse.
REQ-010 SHALL have port ABORT, input, 1 bit: single-cycle abort pulse.
REQ-011 SHALL have port RAND, input, 8 bits: free-running random value.
REQ-012 SHALL have port STATE, output, 2 bits: 0=IDLE, 1=RUN, 2=OVER.
REQ-013 SHALL have port FIELD, output, 2*COLS bits: cell i in [2i+1:2i]; 00=empty, 01=low obstacle, 10=high obstacle.
REQ-014 SHALL have port DINO_UP, output, 1 bit: dino airborne.
REQ-015 SHALL have port TICK, output, 1 bit: one-cycle pulse on each game tick in RUN.
REQ-016 SHALL have port LEVEL, output, 3 bits: current speed level, 0..4.
REQ-017 SHALL have ports SCORE and HISCORE, output, 32 bits each: current and best score.

Function
REQ-018 SHALL, in IDLE, move to RUN on START, clearing FIELD, SCORE, LEVEL, DINO_UP, the pending jump and the tick counter in that cycle.
REQ-019 SHALL, in RUN, assert TICK when the tick counter reaches TICK_CYCLES - LEVEL*(TICK_CYCLES/8) - 1, then restart the counter at 0.
REQ-020 SHALL, in RUN, latch JUMP into a pending flag, and SHALL discard a JUMP that arrives while DINO_UP=1.
REQ-021 SHALL, on a tick with a pending jump and DINO_UP=0, set DINO_UP=1, load the air counter with JUMP_TICKS and clear the pending flag.
REQ-022 SHALL, on a tick with DINO_UP=1, decrement the air counter and clear DINO_UP in the tick on which the counter reaches 0.
REQ-023 SHALL, on each tick, shift FIELD right by one cell; the new top cell is 01 if the top MIN_GAP cells before the shift are empty, RAND[1:0]!=3 and RAND[2]=1; 10 if the same conditions hold with RAND[2]=0; otherwise 00.
REQ-024 SHALL, on each tick, test cell 0 of the post-shift field against the post-update DINO_UP; if the cell is non-empty and DINO_UP=0, it SHALL enter OVER, otherwise it SHALL increment SCORE by 1.
REQ-025 SHALL set LEVEL = min(SCORE/SPEEDUP_SCORE, 4), updated in the cycle after SCORE changes.
REQ-026 SHALL, on ABORT in RUN, enter OVER on the next edge; ABORT SHALL take priority over a tick in the same cycle and SHALL be ignored in IDLE and OVER.
REQ-027 SHALL, on entering OVER, freeze FIELD, SCORE and DINO_UP, and SHALL load HISCORE with SCORE when SCORE > HISCORE.
REQ-028 SHALL, in OVER, return to IDLE on START; START in RUN SHALL be ignored.
REQ-029 SHALL saturate SCORE at 32'hFFFFFFFF.

Reset
REQ-030 SHALL, on RESETN=0, asynchronously set STATE=IDLE, FIELD=0, DINO_UP=0, TICK=0, LEVEL=0, SCORE=0, HISCORE=0, and clear the pending flag, the air counter and the tick counter.
REQ-031 SHALL discard all game progress on a reset taken mid-RUN, with no HISCORE update.

Configuration
REQ-032 SHALL, when RUNNER_HISCORE_EN is defined, implement HISCORE tracking as specified in REQ-027.
REQ-033 SHALL, when RUNNER_HISCORE_EN is undefined, hold HISCORE at constant 0 with no HISCORE register.

Verification (COLS=8, TICK_CYCLES=16, JUMP_TICKS=3, MIN_GAP=2, SPEEDUP_SCORE=4)
REQ-034 SHALL cover: START with RAND=8'h00 held -> STATE=1, with TICK every 16 cycles; FIELD[15:14]=10 after tick 1, then empty for 2 ticks, then 10 again.
REQ-035 SHALL cover: RAND=8'h03 held, 5 ticks -> FIELD=0, SCORE=5, LEVEL=1, tick period 14 cycles.
REQ-036 SHALL cover: obstacle reaching cell 0 with no jump -> STATE=2 on that tick, SCORE unchanged, HISCORE=SCORE.
REQ-037 SHALL cover: JUMP one tick before the obstacle reaches cell 0 -> DINO_UP=1 for exactly 3 ticks, no collision, SCORE keeps incrementing; a second JUMP while airborne produces no extra jump.
REQ-038 SHALL cover: ABORT and TICK in the same cycle -> STATE=2, SCORE not incremented; then START -> STATE=0; then START -> FIELD=0, SCORE=0, HISCORE retained.
REQ-039 SHALL cover: RESETN low mid-RUN -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/runner_game_core.sv
// Endless-runner game core: scrolling obstacle field, jumping dino, score and speed levels.
// Optional feature: define RUNNER_HISCORE_EN to keep a best-score register on HISCORE.
module runner_game_core #(
    parameter int COLS          = 16,
    parameter int TICK_CYCLES   = 250000,
    parameter int JUMP_TICKS    = 3,
    parameter int MIN_GAP       = 5,
    parameter int SPEEDUP_SCORE = 64
) (
    input  logic                CLK,
    input  logic                RESETN,
    input  logic                START,
    input  logic                JUMP,
    input  logic                ABORT,
    input  logic [7:0]          RAND,
    output logic [1:0]          STATE,
    output logic [2*COLS-1:0]   FIELD,
    output logic                DINO_UP,
    output logic                TICK,
    output logic [2:0]          LEVEL,
    output logic [31:0]         SCORE,
    output logic [31:0]         HISCORE
);

    localparam int CW    = $clog2(TICK_CYCLES);
    localparam int STEP  = TICK_CYCLES / 8;
    localparam int SHIFT = $clog2(SPEEDUP_SCORE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   tick_cnt;
    logic [CW-1:0]   tick_limit;
    logic            tick_hit;
    logic            pending;
    logic [2:0]      air_cnt;

    logic            jump_req;
    logic            tick_up;
    logic [2:0]      tick_air;
    logic            tick_pend;

    logic [2*MIN_GAP-1:0] top_cells;
    logic            gap_clear;
    logic [1:0]      new_cell;
    logic [2*COLS-1:0] shifted;
    logic            collide;

    logic [31:0]     score_lvl;
    logic [2:0]      level_calc;
    logic [31:0]     score_inc;
    logic            unused_rand;

    assign unused_rand = ^RAND[7:3];
    assign STATE       = state;

    // Faster levels shave an eighth of the base period off each tick.
    always_comb begin
        tick_limit = CW'(TICK_CYCLES - 1 - int'(LEVEL) * STEP);
        tick_hit   = (state == ST_RUN) && (tick_cnt >= tick_limit);
    end

    always_comb begin
        top_cells = FIELD[2*COLS-1 -: 2*MIN_GAP];
        gap_clear = (top_cells == '0);
        new_cell  = 2'b00;
        if (gap_clear && (RAND[1:0] != 2'b11)) begin
            new_cell = RAND[2] ? 2'b01 : 2'b10;
        end
        shifted = {new_cell, FIELD[2*COLS-1:2]};
    end

    // A jump arriving in the same cycle as a tick is already counted as pending.
    always_comb begin
        jump_req  = pending | (JUMP & ~DINO_UP);
        tick_up   = DINO_UP;
        tick_air  = air_cnt;
        tick_pend = jump_req;
        if (jump_req && !DINO_UP) begin
            tick_up   = 1'b1;
            tick_air  = 3'(JUMP_TICKS);
            tick_pend = 1'b0;
        end else if (DINO_UP) begin
            tick_air = air_cnt - 3'd1;
            if (air_cnt == 3'd1) begin
                tick_up = 1'b0;
            end
        end
        collide = (shifted[1:0] != 2'b00) && !tick_up;
    end

    always_comb begin
        score_lvl  = SCORE >> SHIFT;
        level_calc = (score_lvl >= 32'd4) ? 3'd4 : score_lvl[2:0];
        score_inc  = (SCORE == 32'hFFFF_FFFF) ? SCORE : SCORE + 32'd1;
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state    <= ST_IDLE;
            FIELD    <= '0;
            DINO_UP  <= 1'b0;
            TICK     <= 1'b0;
            LEVEL    <= 3'd0;
            SCORE    <= 32'd0;
            pending  <= 1'b0;
            air_cnt  <= 3'd0;
            tick_cnt <= '0;
        end else begin
            TICK  <= 1'b0;
            LEVEL <= level_calc;
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        state    <= ST_RUN;
                        FIELD    <= '0;
                        SCORE    <= 32'd0;
                        LEVEL    <= 3'd0;
                        DINO_UP  <= 1'b0;
                        pending  <= 1'b0;
                        air_cnt  <= 3'd0;
                        tick_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    if (ABORT) begin
                        state <= ST_OVER;
                    end else if (tick_hit) begin
                        tick_cnt <= '0;
                        TICK     <= 1'b1;
                        FIELD    <= shifted;
                        DINO_UP  <= tick_up;
                        air_cnt  <= tick_air;
                        pending  <= tick_pend;
                        if (collide) begin
                            state <= ST_OVER;
                        end else begin
                            SCORE <= score_inc;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + CW'(1);
                        pending  <= jump_req;
                    end
                end
                ST_OVER: begin
                    if (START) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef RUNNER_HISCORE_EN
    logic        enter_over;
    logic [31:0] hiscore_q;

    assign enter_over = (state == ST_RUN) && (ABORT || (tick_hit && collide));

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            hiscore_q <= 32'd0;
        end else if (enter_over && (SCORE > hiscore_q)) begin
            hiscore_q <= SCORE;
        end
    end

    assign HISCORE = hiscore_q;
`else
    assign HISCORE = 32'd0;
`endif

endmodule

// File: tb/tb_runner_game_core.sv
// Self-checking bench for runner_game_core: directed game scenarios plus random play
// compared every cycle against a cell-array reference model.
module tb_runner_game_core;

    localparam int COLS          = 8;
    localparam int TICK_CYCLES   = 16;
    localparam int JUMP_TICKS    = 3;
    localparam int MIN_GAP       = 2;
    localparam int SPEEDUP_SCORE = 4;

`ifdef RUNNER_HISCORE_EN
    localparam bit HS_EN = 1'b1;
`else
    localparam bit HS_EN = 1'b0;
`endif

    logic              CLK = 1'b0;
    logic              RESETN = 1'b1;
    logic              START = 1'b0;
    logic              JUMP = 1'b0;
    logic              ABORT = 1'b0;
    logic [7:0]        RAND = 8'h00;
    logic [1:0]        STATE;
    logic [2*COLS-1:0] FIELD;
    logic              DINO_UP;
    logic              TICK;
    logic [2:0]        LEVEL;
    logic [31:0]       SCORE;
    logic [31:0]       HISCORE;

    runner_game_core #(
        .COLS(COLS), .TICK_CYCLES(TICK_CYCLES), .JUMP_TICKS(JUMP_TICKS),
        .MIN_GAP(MIN_GAP), .SPEEDUP_SCORE(SPEEDUP_SCORE)
    ) dut (
        .CLK(CLK), .RESETN(RESETN), .START(START), .JUMP(JUMP), .ABORT(ABORT),
        .RAND(RAND), .STATE(STATE), .FIELD(FIELD), .DINO_UP(DINO_UP), .TICK(TICK),
        .LEVEL(LEVEL), .SCORE(SCORE), .HISCORE(HISCORE)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model: game state as plain integers and an array of cells.
    int     m_state;
    int     m_cells[COLS];
    int     m_up, m_air, m_pend, m_cnt, m_level, m_tick, m_ticks;
    longint m_score, m_hiscore;

    int cyc = 0;
    int last_tick_cyc = 0;
    int tick_period = 0;
    int up_ticks;
    int tick_idx;
    int tops[8];
    int periods[8];

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic int periodOf(input int lvl);
        return TICK_CYCLES - lvl * (TICK_CYCLES / 8);
    endfunction

    task automatic modelReset();
        m_state = 0;
        foreach (m_cells[i]) m_cells[i] = 0;
        m_up = 0; m_air = 0; m_pend = 0; m_cnt = 0; m_level = 0; m_tick = 0; m_ticks = 0;
        m_score = 0; m_hiscore = 0;
    endtask

    task automatic modelEnterOver();
        m_state = 2;
        if (HS_EN && (m_score > m_hiscore)) m_hiscore = m_score;
    endtask

    task automatic modelStep(input logic s, input logic j, input logic a, input logic [7:0] r);
        int new_level;
        int gap;
        int newc;
        int rv;
        rv = int'(r);
        new_level = (m_score / SPEEDUP_SCORE > 4) ? 4 : int'(m_score / SPEEDUP_SCORE);
        m_tick = 0;
        case (m_state)
            0: if (s) begin
                m_state = 1;
                foreach (m_cells[i]) m_cells[i] = 0;
                m_score = 0; new_level = 0;
                m_up = 0; m_pend = 0; m_air = 0; m_cnt = 0; m_ticks = 0;
            end
            1: if (a) begin
                modelEnterOver();
            end else begin
                if (j && m_up == 0) m_pend = 1;
                if (m_cnt == periodOf(m_level) - 1) begin
                    gap = 1;
                    for (int i = COLS - MIN_GAP; i < COLS; i++) if (m_cells[i] != 0) gap = 0;
                    newc = (gap == 1 && rv % 4 != 3) ? (((rv / 4) % 2 == 1) ? 1 : 2) : 0;
                    for (int i = 0; i < COLS - 1; i++) m_cells[i] = m_cells[i+1];
                    m_cells[COLS-1] = newc;
                    if (m_pend == 1 && m_up == 0) begin
                        m_up = 1; m_air = JUMP_TICKS; m_pend = 0;
                    end else if (m_up == 1) begin
                        m_air--;
                        if (m_air == 0) m_up = 0;
                    end
                    if (m_cells[0] != 0 && m_up == 0) modelEnterOver();
                    else if (m_score < 64'h0000_0000_FFFF_FFFF) m_score++;
                    m_cnt = 0; m_tick = 1; m_ticks++;
                end else begin
                    m_cnt++;
                end
            end
            2: if (s) m_state = 0;
            default: m_state = 0;
        endcase
        m_level = new_level;
    endtask

    task automatic compareAll();
        logic [2*COLS-1:0] f;
        for (int i = 0; i < COLS; i++) f[2*i +: 2] = 2'(m_cells[i]);
        checkOutput("state",   64'(STATE),   64'(m_state));
        checkOutput("field",   64'(FIELD),   64'(f));
        checkOutput("dino_up", 64'(DINO_UP), 64'(m_up));
        checkOutput("tick",    64'(TICK),    64'(m_tick));
        checkOutput("level",   64'(LEVEL),   64'(m_level));
        checkOutput("score",   64'(SCORE),   64'(m_score));
        checkOutput("hiscore", 64'(HISCORE), 64'(m_hiscore));
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_state"},   64'(STATE),   64'd0);
        checkOutput({tag, "_field"},   64'(FIELD),   64'd0);
        checkOutput({tag, "_dino_up"}, 64'(DINO_UP), 64'd0);
        checkOutput({tag, "_tick"},    64'(TICK),    64'd0);
        checkOutput({tag, "_level"},   64'(LEVEL),   64'd0);
        checkOutput({tag, "_score"},   64'(SCORE),   64'd0);
        checkOutput({tag, "_hiscore"}, 64'(HISCORE), 64'd0);
    endtask

    task automatic applyStimulus(input logic s, input logic j, input logic a, input logic [7:0] r);
        @(negedge CLK);
        START = s; JUMP = j; ABORT = a; RAND = r;
        @(posedge CLK);
        modelStep(s, j, a, r);
        #1;
        cyc++;
        if (TICK) begin
            tick_period = cyc - last_tick_cyc;
            last_tick_cyc = cyc;
            if (tick_idx < 8) begin
                tops[tick_idx] = int'(FIELD[2*COLS-1 -: 2]);
                periods[tick_idx] = tick_period;
            end
            tick_idx++;
            if (DINO_UP) up_ticks++;
        end
        compareAll();
    endtask

    initial begin
        modelReset();
        #2 RESETN = 1'b0;
        #1 checkReset("por");
        repeat (2) @(posedge CLK);
        @(negedge CLK) RESETN = 1'b1;

        // Scenario: RAND=0 spawns high obstacles every third tick; first one kills the dino.
        tick_idx = 0; up_ticks = 0;
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        last_tick_cyc = cyc;
        for (int k = 0; k < 300 && m_state == 1; k++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("s1_top_t1", 64'(tops[0]), 64'd2);
        checkOutput("s1_top_t2", 64'(tops[1]), 64'd0);
        checkOutput("s1_top_t3", 64'(tops[2]), 64'd0);
        checkOutput("s1_top_t4", 64'(tops[3]), 64'd2);
        checkOutput("s1_period_lvl0", 64'(periods[1]), 64'd16);
        checkOutput("s1_over", 64'(STATE), 64'd2);
        checkOutput("s1_score", 64'(SCORE), 64'd7);
        checkOutput("s1_hiscore", 64'(HISCORE), HS_EN ? 64'd7 : 64'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);

        // Scenario: RAND=3 never spawns; five ticks reach level 1 with a shorter period.
        tick_idx = 0;
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h03);
        for (int k = 0; k < 200 && m_ticks < 5; k++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h03);
        checkOutput("s2_field", 64'(FIELD), 64'd0);
        checkOutput("s2_score", 64'(SCORE), 64'd5);
        checkOutput("s2_level", 64'(LEVEL), 64'd1);
        checkOutput("s2_period_lvl1", 64'(tick_period), 64'd14);

        // Scenario: ABORT lands on the same edge as a tick.
        for (int k = 0; k < 40 && m_cnt != periodOf(m_level) - 1; k++)
            applyStimulus(1'b0, 1'b0, 1'b0, 8'h03);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h03);
        checkOutput("s3_over", 64'(STATE), 64'd2);
        checkOutput("s3_score", 64'(SCORE), 64'd5);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h03);
        checkOutput("s3_idle", 64'(STATE), 64'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("s3_field_clr", 64'(FIELD), 64'd0);
        checkOutput("s3_score_clr", 64'(SCORE), 64'd0);
        checkOutput("s3_hiscore_kept", 64'(HISCORE), HS_EN ? 64'd7 : 64'd0);

        // Scenario: one obstacle, jump over it, second JUMP while airborne is discarded.
        up_ticks = 0;
        for (int k = 0; k < 400 && m_ticks < 14; k++) begin
            if (m_ticks == 7 && m_cnt == 3)
                applyStimulus(1'b0, 1'b1, 1'b0, 8'h03);
            else if (m_ticks == 9 && m_cnt == 2)
                applyStimulus(1'b0, 1'b1, 1'b0, 8'h03);
            else
                applyStimulus(1'b0, 1'b0, 1'b0, (m_ticks == 0) ? 8'h00 : 8'h03);
        end
        checkOutput("s4_up_ticks", 64'(up_ticks), 64'd3);
        checkOutput("s4_running", 64'(STATE), 64'd1);
        checkOutput("s4_score", 64'(SCORE), 64'd14);

        // Random play, including ignored START in RUN and rare aborts.
        for (int k = 0; k < 3000; k++) begin
            logic s;
            s = (m_state != 1) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 199) == 0);
            applyStimulus(s, $urandom_range(0, 5) == 0, $urandom_range(0, 299) == 0, 8'($urandom));
        end

        // Asynchronous reset taken mid-RUN.
        for (int k = 0; k < 3 && m_state != 1; k++) applyStimulus(1'b1, 1'b0, 1'b0, 8'h03);
        for (int k = 0; k < 40; k++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h03);
        checkOutput("s6_running", 64'(STATE), 64'd1);
        @(negedge CLK);
        #2 RESETN = 1'b0;
        #1 checkReset("async");
        modelReset();
        repeat (2) @(posedge CLK);
        @(negedge CLK) RESETN = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
